// File: rtl/ddc_retune_ctrl_pkg.sv
// Shared types and constants for the DDC retune controller.
// Phase increments assume a 192 MHz sample clock.
package ddc_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic [31:0] FREQ_75M = 32'h6400_0000;
  localparam logic [31:0] FREQ_32M = 32'h2AAA_AAAB;
  localparam int          SAMPLE_W = 32;

endpackage

// File: rtl/ddc_retune_ctrl.sv
// Retune sequencer for the NCO -> mixer -> CIC -> FIR chain: holds the chain in reset,
// flushes its transients, then forwards settled {I,Q} samples.
module ddc_retune_ctrl
  import ddc_ctrl_pkg::*;
#(
  parameter logic [31:0] DEF_FREQ  = FREQ_75M,
  parameter int          HOLD_CYC  = 8,
  parameter int          FLUSH_SMP = 16,
  parameter int          WDOG_CYC  = 4096,
  parameter int          DW        = SAMPLE_W
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [31:0]   cfg_freq,
  input  logic          cfg_wr,
  input  logic [DW-1:0] ddc_data,
  input  logic          ddc_valid,
  output logic [31:0]   phi_inc,
  output logic          ddc_rst_n,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          busy,
  output logic          retune_done,
  output logic          wdog_err,
  output state_e        dbg_state
);

  // Handshake: ddc_valid qualifies ddc_data for exactly one cycle and there is no
  // back-pressure in either direction; out_valid is a 1-cycle pulse qualifying out_data.

  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int SW = $clog2(FLUSH_SMP + 1);
  localparam int WW = $clog2(WDOG_CYC + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYC - 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(FLUSH_SMP - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(WDOG_CYC - 1);

  state_e        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] smp;
  logic [WW-1:0] wd;
  logic          wd_fire;
  logic          go_hold;

  // A cfg_wr always lands on a HOLD entry edge, so the single pending slot is
  // consumed in the same cycle it is written and needs no storage of its own.
  assign wd_fire   = (state == FLUSH) && !ddc_valid && (wd == WD_LAST);
  assign go_hold   = cfg_wr || wd_fire;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= HOLD;
      phi_inc     <= DEF_FREQ;
      ddc_rst_n   <= 1'b0;
      busy        <= 1'b1;
      out_data    <= '0;
      out_valid   <= 1'b0;
      retune_done <= 1'b0;
      wdog_err    <= 1'b0;
      cnt         <= '0;
      smp         <= '0;
      wd          <= '0;
    end else begin
      retune_done <= 1'b0;
      out_valid   <= 1'b0;

      // Forwarding happens even on the cycle a retune is requested (old-frequency data).
      if (state == RUN && ddc_valid) begin
        out_data  <= ddc_data;
        out_valid <= 1'b1;
      end

      if (wd_fire) begin
        wdog_err <= 1'b1;
      end else if (cfg_wr) begin
        wdog_err <= 1'b0;
      end

      if (go_hold) begin
        state     <= HOLD;
        ddc_rst_n <= 1'b0;
        busy      <= 1'b1;
        cnt       <= '0;
        smp       <= '0;
        wd        <= '0;
        if (cfg_wr) begin
          phi_inc <= cfg_freq;
        end
      end else begin
        case (state)
          HOLD: begin
            if (cnt == CNT_LAST) begin
              state     <= FLUSH;
              ddc_rst_n <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          FLUSH: begin
            if (ddc_valid) begin
              wd <= '0;
              if (smp == SMP_LAST) begin
                state       <= RUN;
                busy        <= 1'b0;
                retune_done <= 1'b1;
                smp         <= '0;
              end else begin
                smp <= smp + 1'b1;
              end
            end else if (wd != '1) begin
              wd <= wd + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddc_retune_ctrl.sv
// Randomized bench for ddc_retune_ctrl against a countdown-based reference model
// plus an output scoreboard.
module tb_ddc_retune_ctrl;
  import ddc_ctrl_pkg::*;

  localparam int HOLD_CYC  = 8;
  localparam int FLUSH_SMP = 16;
  localparam int WDOG_CYC  = 4096;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] cfg_freq;
  logic        cfg_wr;
  logic [31:0] ddc_data;
  logic        ddc_valid;
  logic [31:0] phi_inc;
  logic        ddc_rst_n;
  logic [31:0] out_data;
  logic        out_valid;
  logic        busy;
  logic        retune_done;
  logic        wdog_err;
  state_e      dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ddc_retune_ctrl dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .cfg_freq    (cfg_freq),
    .cfg_wr      (cfg_wr),
    .ddc_data    (ddc_data),
    .ddc_valid   (ddc_valid),
    .phi_inc     (phi_inc),
    .ddc_rst_n   (ddc_rst_n),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .busy        (busy),
    .retune_done (retune_done),
    .wdog_err    (wdog_err),
    .dbg_state   (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  int          m_hold_left;   // chain-reset cycles still to go
  int          m_drop_left;   // samples still to discard
  int          m_idle;        // cycles since last sample while discarding
  logic [31:0] m_phi;
  logic [31:0] m_odata;
  logic        m_err;
  logic        m_ovalid;
  logic        m_done;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold_left = HOLD_CYC;
    m_drop_left = FLUSH_SMP;
    m_idle      = 0;
    m_phi       = FREQ_75M;
    m_odata     = '0;
    m_err       = 1'b0;
    m_ovalid    = 1'b0;
    m_done      = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic restart;
    logic fired;
    restart  = 1'b0;
    fired    = 1'b0;
    m_done   = 1'b0;
    m_ovalid = 1'b0;
    if (m_hold_left > 0) begin
      m_hold_left--;
      m_idle = 0;
    end else if (m_drop_left > 0) begin
      if (ddc_valid) begin
        m_drop_left--;
        m_idle = 0;
        if (m_drop_left == 0) m_done = 1'b1;
      end else begin
        m_idle++;
        if (m_idle == WDOG_CYC) begin
          fired   = 1'b1;
          m_err   = 1'b1;
          restart = 1'b1;
        end
      end
    end else if (ddc_valid) begin
      m_ovalid = 1'b1;
      m_odata  = ddc_data;
      exp_q.push_back(ddc_data);
    end
    if (cfg_wr) begin
      restart = 1'b1;
      m_phi   = cfg_freq;
      if (!fired) m_err = 1'b0;
    end
    if (restart) begin
      m_hold_left = HOLD_CYC;
      m_drop_left = FLUSH_SMP;
      m_idle      = 0;
      m_done      = 1'b0;
    end
  endtask

  // ---------------- scoreboard / per-cycle checks ----------------
  task automatic check_all();
    logic        running;
    logic [31:0] exp_d;
    running = (m_hold_left == 0) && (m_drop_left == 0);
    chk("phi_inc", phi_inc, m_phi);
    chk("ddc_rst_n", ddc_rst_n, m_hold_left == 0);
    chk("busy", busy, !running);
    chk("dbg_state_run", dbg_state == RUN, running);
    chk("out_valid", out_valid, m_ovalid);
    chk("retune_done", retune_done, m_done);
    chk("wdog_err", wdog_err, m_err);
    chk("out_data", out_data, m_odata);
    if (out_valid) begin
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        chk("sb_data", out_data, exp_d);
      end
    end
    if (retune_done) done_seen++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic wr, input logic [31:0] f, input logic v);
    cfg_wr    = wr;
    cfg_freq  = f;
    ddc_valid = v;
    ddc_data  = $urandom();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_rand(input int n, input int vpct);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, $urandom(), $urandom_range(99, 0) < vpct);
    end
  endtask

  task automatic async_reset(input string tag, input logic wr);
    cfg_wr    = wr;
    cfg_freq  = $urandom();
    ddc_valid = wr;
    #2;
    n_rst = 1'b0;
    #1;
    chk({tag, "_phi"}, phi_inc, FREQ_75M);
    chk({tag, "_ddc_rst_n"}, ddc_rst_n, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_done"}, retune_done, 0);
    chk({tag, "_wdog"}, wdog_err, 0);
    model_reset();
    @(negedge clk);
    cfg_wr    = 1'b0;
    ddc_valid = 1'b0;
    n_rst     = 1'b1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    logic [31:0] fb;
    n_rst     = 1'b1;
    cfg_wr    = 1'b0;
    cfg_freq  = '0;
    ddc_valid = 1'b0;
    ddc_data  = '0;
    model_reset();
    async_reset("rst0", 1'b0);

    // Test 1: release with a sample every 4th cycle
    for (int i = 0; i < 120; i++) cyc(1'b0, $urandom(), (i % 4) == 3);
    chk("t1_done_once", done_seen, 1);

    // Test 2: retune from RUN
    d0 = done_seen;
    cyc(1'b1, 32'h2222_2222, $urandom_range(1, 0));
    run_rand(120, 70);
    chk("t2_phi", phi_inc, 32'h2222_2222);
    chk("t2_done_once", done_seen - d0, 1);

    // Test 3: retune request coincident with a RUN sample
    run_rand(5, 50);
    d0 = done_seen;
    cyc(1'b1, FREQ_32M, 1'b1);
    run_rand(120, 70);
    chk("t3_phi", phi_inc, FREQ_32M);
    chk("t3_done_once", done_seen - d0, 1);

    // Test 4: second request aborts the sequence during FLUSH
    d0 = done_seen;
    cyc(1'b1, $urandom(), 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b0, $urandom(), 1'b1);
    fb = $urandom();
    cyc(1'b1, fb, 1'b1);
    run_rand(120, 70);
    chk("t4_phi_b", phi_inc, fb);
    chk("t4_done_once", done_seen - d0, 1);

    // Test 5: watchdog, automatic restart, set-over-clear priority, then clear
    cyc(1'b1, FREQ_32M, 1'b0);
    for (int i = 0; i < HOLD_CYC + WDOG_CYC + 4 && !wdog_err; i++) cyc(1'b0, $urandom(), 1'b0);
    chk("t5_err_set", wdog_err, 1);
    cyc(1'b0, $urandom(), 1'b0);
    chk("t5_restart_hold", ddc_rst_n, 0);
    for (int i = 0; i < HOLD_CYC + WDOG_CYC + 4 &&
         !(m_hold_left == 0 && m_drop_left > 0 && m_idle == WDOG_CYC - 1); i++) begin
      cyc(1'b0, $urandom(), 1'b0);
    end
    cyc(1'b1, FREQ_75M, 1'b0);
    chk("t5_set_prio", wdog_err, 1);
    run_rand(20, 0);
    cyc(1'b1, FREQ_32M, 1'b1);
    chk("t5_clear", wdog_err, 0);
    run_rand(120, 70);

    // Test 6: asynchronous reset in FLUSH and in RUN, pending request discarded
    cyc(1'b1, $urandom(), 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b0, $urandom(), 1'b1);
    async_reset("t6_flush", 1'b1);
    run_rand(30, 70);
    chk("t6_phi_default", phi_inc, FREQ_75M);
    run_rand(120, 70);
    async_reset("t6_run", 1'b1);
    run_rand(30, 70);
    chk("t6_phi_default2", phi_inc, FREQ_75M);

    // Soak: random retunes over random sample traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(199, 0) == 0, $urandom(), $urandom_range(99, 0) < 60);
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
